// File: rtl/synth_pkg.sv
// Shared types for the synth voice path: note codes, voice ownership and
// the arbiter FSM state encoding.
package synth_pkg;

   typedef logic [3:0] note_t;
   localparam note_t NOTE_NONE = 4'd0;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_LIVE = 2'd1,
      SRC_SEQ  = 2'd2
   } voice_src_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LIVE      = 2'd1,
      ST_LIVE_HOLD = 2'd2,
      ST_SEQ       = 2'd3
   } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at MAX and flags it; clear has priority over enable.
module sat_counter #(
   parameter int WIDTH = 12,
   parameter int MAX   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             at_limit
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   assign at_limit = (count == MAX_V);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (en && !at_limit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/voice_arbiter.sv
// Arbitrates the single tone voice between live keypad notes and the step
// sequencer: live pre-empts, live notes get a minimum gate, and the sequencer
// stays muted for a hold-off after a live release.
module voice_arbiter
   import synth_pkg::*;
#(
   parameter int MIN_GATE     = 200,
   parameter int RELEASE_HOLD = 500,
   parameter int CNT_W        = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] live_note,
   input  logic [3:0] seq_note,
   input  logic       sequencer_on,
   output logic [3:0] voice_note,
   output logic       gate,
   output logic       retrig,
   output logic [1:0] src
);

   arb_state_t state_q, state_d;
   note_t      voice_q, voice_d;
   voice_src_t src_q, src_d;
   logic       gate_q, retrig_q, retrig_d;

   logic live_req, seq_req;
   logic gate_clr, gate_en, gate_max;
   logic hold_clr, hold_en, hold_max;
   logic [CNT_W-1:0] gate_cnt, hold_cnt;

   assign live_req = (live_note != NOTE_NONE);
   assign seq_req  = sequencer_on && (seq_note != NOTE_NONE);

   // gate_cnt restarts whenever a live note begins or changes; it only runs in LIVE.
   assign gate_clr = (state_d == ST_LIVE) && live_req &&
                     ((state_q != ST_LIVE) || (live_note != voice_q));
   assign gate_en  = (state_q == ST_LIVE);
   // hold_cnt sits at zero outside LIVE_HOLD so it starts from 0 on entry.
   assign hold_clr = (state_q != ST_LIVE_HOLD);
   assign hold_en  = (state_q == ST_LIVE_HOLD);

   sat_counter #(.WIDTH(CNT_W), .MAX(MIN_GATE - 1)) u_gate_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (gate_clr),
      .en       (gate_en),
      .count    (gate_cnt),
      .at_limit (gate_max)
   );

   sat_counter #(.WIDTH(CNT_W), .MAX(RELEASE_HOLD - 1)) u_hold_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (hold_clr),
      .en       (hold_en),
      .count    (hold_cnt),
      .at_limit (hold_max)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         voice_q  <= NOTE_NONE;
         src_q    <= SRC_NONE;
         gate_q   <= 1'b0;
         retrig_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         voice_q  <= voice_d;
         src_q    <= src_d;
         gate_q   <= (voice_d != NOTE_NONE);
         retrig_q <= retrig_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (live_req)     state_d = ST_LIVE;
            else if (seq_req) state_d = ST_SEQ;
         end
         ST_LIVE: begin
            if (!live_req && gate_max) state_d = ST_LIVE_HOLD;
         end
         ST_LIVE_HOLD: begin
            if (live_req)      state_d = ST_LIVE;
            else if (hold_max) state_d = ST_IDLE;
         end
         ST_SEQ: begin
            if (live_req)      state_d = ST_LIVE;
            else if (!seq_req) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next output values follow from the state being entered.
   always_comb begin
      voice_d = NOTE_NONE;
      src_d   = SRC_NONE;
      case (state_d)
         ST_LIVE: begin
            voice_d = live_req ? live_note : voice_q;
            src_d   = SRC_LIVE;
         end
         ST_LIVE_HOLD: begin
            src_d = SRC_LIVE;
         end
         ST_SEQ: begin
            voice_d = seq_note;
            src_d   = SRC_SEQ;
         end
         default: begin
            voice_d = NOTE_NONE;
            src_d   = SRC_NONE;
         end
      endcase
      retrig_d = (voice_d != NOTE_NONE) && (voice_d != voice_q);
   end

   assign voice_note = voice_q;
   assign gate       = gate_q;
   assign retrig     = retrig_q;
   assign src        = src_q;

   a_counters_bounded : assert property (@(posedge clk)
      (gate_cnt <= CNT_W'(MIN_GATE - 1)) && (hold_cnt <= CNT_W'(RELEASE_HOLD - 1)));
   a_gate_matches_note : assert property (@(posedge clk)
      gate_q == (voice_q != NOTE_NONE));

endmodule

// File: tb/tb_voice_arbiter.sv
// Randomised and directed bench for voice_arbiter against an ownership-based
// reference model of the arbitration rules.
module tb_voice_arbiter;

   localparam int MIN_GATE     = 4;
   localparam int RELEASE_HOLD = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] live_note = '0;
   logic [3:0] seq_note = '0;
   logic       sequencer_on = 1'b0;
   logic [3:0] voice_note;
   logic       gate;
   logic       retrig;
   logic [1:0] src;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: who owns the voice, what it plays, and elapsed times
   int   m_owner;    // 0 none, 1 live, 2 seq
   int   m_note;
   int   m_age;      // cycles since the current live note (re)started
   int   m_muted;    // cycles spent silent after a live release
   bit   m_holding;
   bit   m_retrig;
   logic [7:0] exp_v;
   wire  [7:0] obs = {voice_note, gate, retrig, src};

   voice_arbiter #(
      .MIN_GATE     (MIN_GATE),
      .RELEASE_HOLD (RELEASE_HOLD),
      .CNT_W        (12)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .live_note    (live_note),
      .seq_note     (seq_note),
      .sequencer_on (sequencer_on),
      .voice_note   (voice_note),
      .gate         (gate),
      .retrig       (retrig),
      .src          (src)
   );

   always #5 clk = ~clk;

   task automatic model_step(input int l, input int s, input bit on, input bit r);
      int prev;
      prev = m_note;
      if (r) begin
         m_owner = 0; m_note = 0; m_age = 0; m_muted = 0; m_holding = 0;
      end else if (l != 0) begin
         if (m_owner == 1 && !m_holding && l == m_note) m_age++;
         else m_age = 0;
         m_owner = 1; m_holding = 0; m_note = l;
      end else if (m_owner == 1 && !m_holding) begin
         if (m_age >= MIN_GATE - 1) begin
            m_holding = 1; m_note = 0; m_muted = 0;
         end else begin
            m_age++;
         end
      end else if (m_owner == 1) begin
         if (m_muted == RELEASE_HOLD - 1) begin
            m_owner = 0; m_holding = 0;
         end else begin
            m_muted++;
         end
      end else if (on && s != 0) begin
         m_owner = 2; m_note = s;
      end else begin
         m_owner = 0; m_note = 0;
      end
      m_retrig = !r && (m_note != 0) && (m_note != prev);
      exp_v = {4'(m_note), (m_note != 0), m_retrig, 2'(m_owner)};
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic drive(input logic [3:0] l, input logic [3:0] s, input logic on, input logic r);
      live_note = l; seq_note = s; sequencer_on = on; rst = r;
      @(posedge clk);
      model_step(int'(l), int'(s), on, r);
      #1;
   endtask

   task automatic do_reset();
      drive(4'd0, 4'd0, 1'b0, 1'b1);
      drive(4'd0, 4'd0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(4'd5, 4'd3, 1'b1, 1'b1);
         n_checks++;
         if (obs !== 8'h00) $display("FAIL reset cyc %0d: got %h want 00", i, obs);
         else n_pass++;
      end
      drive(4'd5, 4'd3, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {4'd5, 1'b1, 1'b1, 2'd1}) $display("FAIL reset_release: got %h want %h", obs, {4'd5, 1'b1, 1'b1, 2'd1});
      else n_pass++;
      drive(4'd5, 4'd3, 1'b1, 1'b0);
      n_checks++;
      if (retrig !== 1'b0 || obs !== exp_v) $display("FAIL reset_retrig_once: got %h want %h", obs, exp_v);
      else n_pass++;
   endtask

   task automatic test_min_gate();
      int on_cycles = 0;
      int held_cycles = 0;
      do_reset();
      drive(4'd7, 4'd0, 1'b0, 1'b0);
      if (voice_note == 4'd7) on_cycles++;
      for (int i = 0; i < 14; i++) begin
         drive(4'd0, 4'd0, 1'b0, 1'b0);
         if (voice_note == 4'd7) on_cycles++;
         if (voice_note == 4'd0 && src == 2'd1) held_cycles++;
         n_checks++;
         if (obs !== exp_v) $display("FAIL min_gate cyc %0d: got %h want %h", i, obs, exp_v);
         else n_pass++;
      end
      n_checks++;
      if (on_cycles != MIN_GATE) $display("FAIL min_gate_len: got %0d want %0d", on_cycles, MIN_GATE);
      else n_pass++;
      n_checks++;
      if (held_cycles != RELEASE_HOLD) $display("FAIL hold_len: got %0d want %0d", held_cycles, RELEASE_HOLD);
      else n_pass++;
   endtask

   task automatic test_preempt();
      int waited = 0;
      do_reset();
      drive(4'd0, 4'd2, 1'b1, 1'b0);
      drive(4'd0, 4'd2, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {4'd2, 1'b1, 1'b0, 2'd2}) $display("FAIL seq_owns: got %h want %h", obs, {4'd2, 1'b1, 1'b0, 2'd2});
      else n_pass++;
      drive(4'd9, 4'd2, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {4'd9, 1'b1, 1'b1, 2'd1}) $display("FAIL preempt: got %h want %h", obs, {4'd9, 1'b1, 1'b1, 2'd1});
      else n_pass++;
      do begin
         drive(4'd0, 4'd2, 1'b1, 1'b0);
         waited++;
         n_checks++;
         if (obs !== exp_v) $display("FAIL preempt_release cyc %0d: got %h want %h", waited, obs, exp_v);
         else n_pass++;
      end while (voice_note != 4'd2 && waited < 40);
      n_checks++;
      if (voice_note !== 4'd2 || retrig !== 1'b1 || waited < MIN_GATE - 1 + RELEASE_HOLD)
         $display("FAIL seq_return: got note %0d retrig %b after %0d cycles want note 2 retrig 1 after >= %0d",
                  voice_note, retrig, waited, MIN_GATE - 1 + RELEASE_HOLD);
      else n_pass++;
   endtask

   task automatic test_hold_repress();
      do_reset();
      drive(4'd7, 4'd0, 1'b0, 1'b0);
      // three more gated cycles, the release edge, then three hold increments
      for (int i = 0; i < 7; i++) drive(4'd0, 4'd5, 1'b1, 1'b0);
      drive(4'd4, 4'd5, 1'b1, 1'b0);
      n_checks++;
      if (obs !== {4'd4, 1'b1, 1'b1, 2'd1}) $display("FAIL hold_repress: got %h want %h", obs, {4'd4, 1'b1, 1'b1, 2'd1});
      else n_pass++;
      for (int i = 0; i < MIN_GATE; i++) begin
         drive(4'd0, 4'd5, 1'b1, 1'b0);
         n_checks++;
         if (obs !== exp_v) $display("FAIL hold_regate cyc %0d: got %h want %h", i, obs, exp_v);
         else n_pass++;
      end
      n_checks++;
      if (voice_note !== 4'd0 || src !== 2'd1) $display("FAIL hold_regate_end: got %h want note 0 src 1", obs);
      else n_pass++;
   endtask

   task automatic test_seq_tracking();
      logic [3:0] notes [4];
      logic       want_retrig [4];
      notes = '{4'd3, 4'd3, 4'd6, 4'd0};
      want_retrig = '{1'b1, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(4'd0, notes[i], 1'b1, 1'b0);
         n_checks++;
         if (voice_note !== notes[i] || retrig !== want_retrig[i] || gate !== (notes[i] != 4'd0) || obs !== exp_v)
            $display("FAIL seq_track step %0d: got %h want note %0d retrig %b", i, obs, notes[i], want_retrig[i]);
         else n_pass++;
      end
      drive(4'd0, 4'd5, 1'b1, 1'b0);
      drive(4'd0, 4'd5, 1'b0, 1'b0);
      n_checks++;
      if (obs !== 8'h00) $display("FAIL seq_disable: got %h want 00", obs);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [3:0] l = '0, s = '0;
      logic       on = 1'b1, r;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         if ($urandom_range(0, 5) == 0) s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) on = ~on;
         r = ($urandom_range(0, 299) == 0);
         drive(l, s, on, r);
         n_checks++;
         if (obs !== exp_v) $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_v);
         else n_pass++;
      end
   endtask

   initial begin
      m_owner = 0; m_note = 0; m_age = 0; m_muted = 0; m_holding = 0; m_retrig = 0;
      exp_v = '0;
      test_reset();
      test_min_gate();
      test_preempt();
      test_hold_repress();
      test_seq_tracking();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/voice_arbiter.md
Name: voice_arbiter

Overview:
Shares the single tone-generator voice between live keypad notes and the step sequencer's note output.
- Live playing always pre-empts the sequencer.
- Live notes are held for a minimum gate time.
- After a live release, sequencer playback returns only after a hold-off, so the voice does not flap between sources.
- Sits between the keypad note encoder, the sequencer, and the oscillator/envelope; runs on the 10 kHz system clock.

Parameters:
- MIN_GATE, 200: minimum cycles a live note sounds once started (20 ms).
- RELEASE_HOLD, 500: cycles the sequencer stays muted after a live release (50 ms).
- CNT_W, 12: width of the gate and hold counters. Both parameters must be >= 1 and < 2^CNT_W.

Ports:
- clk  in  1  10 kHz system clock.
- rst  in  1  reset, synchronous, active-high.
- live_note  in  4  keypad note code; 0 = no key.
- seq_note  in  4  sequencer note_sustain; 0 = silent.
- sequencer_on  in  1  sequencer enabled.
- voice_note  out  4  note code to oscillator; 0 = silent.
- gate  out  1  voice sounding.
- retrig  out  1  one-cycle pulse; envelope restarts.
- src  out  2  owner of the voice: 0 none, 1 live, 2 seq.

Behaviour:
- All outputs are registered. Input to output latency is 1 cycle.
- Reset: state IDLE; voice_note=0, gate=0, retrig=0, src=0; counters=0. rst overrides all other inputs in the same cycle.
- A mid-note rst silences the voice on the next edge; no retrig is issued.
- Invariant: gate = (voice_note != 0) at all times.
- FSM states: IDLE, LIVE, LIVE_HOLD, SEQ.
- IDLE:
  - live_note != 0 -> LIVE: voice_note=live_note, retrig=1, gate_cnt=0.
  - else sequencer_on && seq_note != 0 -> SEQ: voice_note=seq_note, retrig=1.
  - If both request in the same cycle, live wins.
- LIVE:
  - gate_cnt increments each cycle and saturates at MIN_GATE-1.
  - live_note nonzero and different from voice_note -> voice_note updated, retrig=1, gate_cnt=0.
  - live_note == 0 with gate_cnt < MIN_GATE-1 -> stay in LIVE, note frozen.
  - live_note == 0 with gate_cnt == MIN_GATE-1 -> LIVE_HOLD: voice_note=0, src=1 retained, hold_cnt=0.
  - A new nonzero live_note during the frozen extension is treated as a note change.
- LIVE_HOLD:
  - Voice silent; seq_note is ignored.
  - live_note != 0 -> LIVE with retrig=1, gate_cnt=0.
  - else hold_cnt == RELEASE_HOLD-1 -> IDLE, src=0.
  - else hold_cnt increments.
- SEQ:
  - voice_note tracks seq_note.
  - seq_note nonzero and different from current -> retrig=1.
  - live_note != 0 -> LIVE in that same cycle: pre-emption, retrig=1, gate_cnt=0.
  - seq_note == 0 or sequencer_on == 0 -> IDLE: voice silenced next cycle. No minimum gate applies to sequencer notes.
- retrig is asserted only on the edge where voice_note changes to a new nonzero value. Re-presenting the same note never retriggers.
- Counter rules: counters are unsigned CNT_W bits; they never wrap; compares are equality against parameter-1.

Decomposition:
- Shared package synth_pkg holds:
  - typedef note_t (logic [3:0]), with NOTE_NONE = 4'd0.
  - enum voice_src_t: SRC_NONE, SRC_LIVE, SRC_SEQ.
  - enum arb_state_t for the FSM states.
- One sub-module is natural: sat_counter, a parameterised width/limit counter with clear, enable and at_limit. It is instanced for gate_cnt and hold_cnt.
- The FSM and output registers stay in voice_arbiter.

Test Plan:
- Run with MIN_GATE=4, RELEASE_HOLD=6.
- Reset / IDLE: rst high 3 cycles with live_note=5, seq_note=3 -> all outputs 0 throughout; release rst -> next edge voice_note=5, src=1, retrig pulse 1 cycle.
- Min gate: live_note=7 for 1 cycle, then 0 -> voice_note=7 for exactly 4 cycles, then 0. Sequencer remains muted for 6 more cycles, then src=0.
- Pre-emption: sequencer_on=1, seq_note=2 (src=2); live_note=9 -> next edge voice_note=9, src=1, retrig=1. Release live -> seq_note=2 returns only after 4 gate + 6 hold cycles, with retrig.
- Hold re-press: during LIVE_HOLD at hold_cnt=3, live_note=4 -> voice_note=4, retrig=1, src=1, gate_cnt restarts.
- Sequencer tracking: seq_note 3 -> 3 -> 6 -> 0 -> retrig only on the transitions to 3 and to 6; gate drops the cycle after 0. Drop sequencer_on mid-note -> voice_note=0 next edge, src=0.
